// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo initiator and its UART helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ECHO,
    ST_CHECK,
    ST_NEXT,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] ERR_SAT   = 8'hFF;
  localparam logic       LINE_IDLE = 1'b1;

  // Error counter increment that sticks at ERR_SAT instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// One-cycle tick at the line bit rate, derived from the system clock.
module baud_gen #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned DIV = (CLK_FREQ / BAUD > 1) ? CLK_FREQ / BAUD : 2;
  localparam int          CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Free-running divider; tick on the last count of each bit period.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LAST);
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/echo_timer.sv
// Echo window timer: held clear outside the wait, counts baud ticks, stops at the limit.
module echo_timer #(
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_TICKS);

  logic [CW-1:0] r_cnt;

  // Count ticks from the moment clear is released; saturate at the limit.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                         r_cnt <= '0;
    else if (i_clear)                  r_cnt <= '0;
    else if (i_tick && r_cnt != LIMIT) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver with its own bit timing; samples each bit near its centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_done,
  output logic       o_error,
  output logic [7:0] o_data
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_done;
  logic          r_error;
  logic [7:0]    r_data;

  // Synchronise the line, start on a falling edge, shift LSB first, flag a low stop bit.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RX_IDLE;
      r_sync1 <= LINE_IDLE;
      r_sync2 <= LINE_IDLE;
      r_prev  <= LINE_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_data  <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_done  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_error <= ~r_sync2;
            r_data  <= r_shift;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_done  = r_done;
  assign o_error = r_error;
  assign o_data  = r_data;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; every bit, including the start bit, lasts one full baud tick period.
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy
);

  logic [9:0] r_shift;
  logic [3:0] r_idx;
  logic       r_tx;
  logic       r_busy;

  // Accept a byte when idle, then emit start/data/stop on successive ticks;
  // busy drops on the tick that ends the stop bit.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= LINE_IDLE;
      r_busy  <= 1'b0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_shift <= {1'b1, i_data, 1'b0};
        r_idx   <= '0;
        r_busy  <= 1'b1;
      end
    end else if (i_tick) begin
      if (r_idx == 4'd10) begin
        r_busy <= 1'b0;
        r_tx   <= LINE_IDLE;
      end else begin
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[9:1]};
        r_idx   <= r_idx + 4'd1;
      end
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;

endmodule

// File: rtl/uart_echo_initiator.sv
// Sends seed, seed+1, ... over tx and checks each byte comes back on rx within the echo window.
module uart_echo_initiator
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD          = 9600,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] num_bytes,
  input  logic [7:0] seed,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       timeout
);

  logic       w_rst;
  logic       w_tick;
  logic       w_tx_busy;
  logic       w_rx_done;
  logic       w_rx_err;
  logic [7:0] w_rx_data;
  logic       w_expired;
  logic       w_tmr_clear;
  logic       w_capture;

  state_t     r_state;
  logic [7:0] r_num;
  logic [7:0] r_byte;
  logic [7:0] r_idx;
  logic [7:0] r_err;
  logic       r_timeout;
  logic       r_pass;
  logic       r_done;
  logic       r_busy;
  logic       r_tx_start;
  logic       r_seen_busy;
  logic       r_byte_err;
  logic       r_echo_vld;
  logic       r_echo_err;
  logic       r_echo_extra;
  logic [7:0] r_echo_data;

  assign w_rst       = ~reset_n;
  assign w_tmr_clear = (r_state != ST_WAIT_ECHO);
  // An echo can finish while our stop bit is still on the line, so listen from SEND onward.
  assign w_capture   = (r_state == ST_SEND) || (r_state == ST_WAIT_ECHO) || (r_state == ST_CHECK);

  baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud (
    .clk    (clk),
    .i_rst  (w_rst),
    .o_tick (w_tick)
  );

  uart_tx u_tx (
    .clk     (clk),
    .i_rst   (w_rst),
    .i_tick  (w_tick),
    .i_start (r_tx_start),
    .i_data  (r_byte),
    .o_tx    (tx),
    .o_busy  (w_tx_busy)
  );

  uart_rx #(.CLKS_PER_BIT(CLK_FREQ / BAUD)) u_rx (
    .clk     (clk),
    .i_rst   (w_rst),
    .i_rx    (rx),
    .o_done  (w_rx_done),
    .o_error (w_rx_err),
    .o_data  (w_rx_data)
  );

  echo_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timer (
    .clk       (clk),
    .i_rst     (w_rst),
    .i_clear   (w_tmr_clear),
    .i_tick    (w_tick),
    .o_expired (w_expired)
  );

  // Hold the first echo of the current byte; any further echo before NEXT marks the byte bad.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_echo_vld   <= 1'b0;
      r_echo_err   <= 1'b0;
      r_echo_extra <= 1'b0;
      r_echo_data  <= '0;
    end else if (r_state == ST_LOAD || r_state == ST_NEXT) begin
      r_echo_vld   <= 1'b0;
      r_echo_extra <= 1'b0;
    end else if (w_capture && w_rx_done) begin
      if (r_echo_vld) begin
        r_echo_extra <= 1'b1;
      end else begin
        r_echo_vld  <= 1'b1;
        r_echo_err  <= w_rx_err;
        r_echo_data <= w_rx_data;
      end
    end
  end

  // Run sequencer: send a byte, wait for its echo or the window to close, score it, repeat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_num       <= '0;
      r_byte      <= '0;
      r_idx       <= '0;
      r_err       <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_start  <= 1'b0;
      r_seen_busy <= 1'b0;
      r_byte_err  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num     <= num_bytes;
            r_byte    <= seed;
            r_idx     <= '0;
            r_err     <= '0;
            r_timeout <= 1'b0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_num == 8'd0) begin
            r_state <= ST_FINISH;
          end else begin
            r_tx_start  <= 1'b1;
            r_seen_busy <= 1'b0;
            r_byte_err  <= 1'b0;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_tx_busy)        r_seen_busy <= 1'b1;
          else if (r_seen_busy) r_state     <= ST_WAIT_ECHO;
        end
        ST_WAIT_ECHO: begin
          if (r_echo_vld || w_rx_done) begin
            r_state <= ST_CHECK;
          end else if (w_expired) begin
            r_err      <= sat_inc(r_err);
            r_timeout  <= 1'b1;
            r_byte_err <= 1'b1;
            r_state    <= ST_NEXT;
          end
        end
        ST_CHECK: begin
          if (r_echo_err || r_echo_extra || (r_echo_data != r_byte)) begin
            r_err      <= sat_inc(r_err);
            r_byte_err <= 1'b1;
          end
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          // A duplicate echo landing during CHECK is only seen here.
          if (r_echo_extra && !r_byte_err) r_err <= sat_inc(r_err);
          if (r_idx + 8'd1 == r_num) begin
            r_state <= ST_FINISH;
          end else begin
            r_idx       <= r_idx + 8'd1;
            r_byte      <= r_byte + 8'd1;
            r_tx_start  <= 1'b1;
            r_seen_busy <= 1'b0;
            r_byte_err  <= 1'b0;
            r_state     <= ST_SEND;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_pass  <= (r_err == 8'd0) && !r_timeout;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_uart_echo_initiator.sv
// Scoreboard bench for uart_echo_initiator with a behavioural responder on the serial line.
module tb_uart_echo_initiator;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int TO_TICKS = 40;

  // Responder behaviour: 0 loopback, 1 silent, 2 flip bit0 of bytes 1 and 3, 3 bad stop on byte 0
  localparam int M_LOOP = 0, M_SILENT = 1, M_FLIP = 2, M_BADSTOP = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_bytes = '0;
  logic [7:0] seed = '0;
  logic       rx;
  logic       tx, busy, done, pass, timeout;
  logic [7:0] err_count;

  int   mode = M_LOOP;
  logic r_rx_drv = 1'b1;
  assign rx = (mode == M_LOOP) ? tx : r_rx_drv;

  uart_echo_initiator #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_TICKS(TO_TICKS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .num_bytes (num_bytes),
    .seed      (seed),
    .rx        (rx),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] err;
    logic       to;
    logic       ps;
  } res_t;

  res_t       exp_res[$];
  logic [7:0] exp_line[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int bytes_seen = 0;
  int run_byte = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: every done pulse is matched against the oldest expected run result.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen++;
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got 1 expected 0 at %0t", $time);
        end else begin
          r = exp_res.pop_front();
          check("err_count", err_count, r.err);
          check("timeout", timeout, r.to);
          check("pass", pass, r.ps);
        end
      end
    end
  end

  task automatic send_echo(input logic [7:0] d, input logic stop_bit);
    r_rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      r_rx_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
    r_rx_drv = stop_bit;
    repeat (BIT) @(negedge clk);
    r_rx_drv = 1'b1;
  endtask

  // Line monitor and responder: decode each tx frame, score it, and echo per the current mode.
  initial begin
    logic [7:0] b;
    logic       stop_b;
    int         k;
    forever begin
      @(negedge tx);
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = tx;
      end
      repeat (BIT) @(negedge clk);
      stop_b = tx;
      bytes_seen++;
      k = run_byte;
      run_byte++;
      if (exp_line.size() > 0) begin
        check("line_byte", b, exp_line.pop_front());
        check("line_stop", stop_b, 1'b1);
      end
      if (mode == M_FLIP || mode == M_BADSTOP) begin
        automatic logic [7:0] eb = b ^ {7'd0, (mode == M_FLIP) && (k == 1 || k == 3)};
        automatic logic       es = !((mode == M_BADSTOP) && (k == 0));
        fork
          send_echo(eb, es);
        join_none
      end
    end
  end

  task automatic issue_run(input logic [7:0] n, input logic [7:0] s, input logic [7:0] e_err,
                           input logic e_to, input logic e_pass);
    res_t r;
    r.err = e_err;
    r.to  = e_to;
    r.ps  = e_pass;
    exp_res.push_back(r);
    for (int i = 0; i < n; i++) exp_line.push_back(s + 8'(i));
    run_byte  = 0;
    num_bytes = n;
    seed      = s;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int target;
    int c;
    target = done_seen + 1;
    c = 0;
    while (done_seen < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_within_budget", done_seen >= target, 1'b1);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
  endtask

  // Hard stop so a wedged run still terminates.
  initial begin
    #600000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;
    res_t r;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err", err_count, 8'd0);
    check("rst_timeout", timeout, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback with wrap FE,FF,00,01
    mode = M_LOOP;
    issue_run(8'd4, 8'hFE, 8'd0, 1'b0, 1'b1);
    wait_done(3000);
    repeat (20) @(negedge clk);

    // Silent responder: every byte times out
    mode = M_SILENT;
    r_rx_drv = 1'b1;
    issue_run(8'd3, 8'h10, 8'd3, 1'b1, 1'b0);
    wait_done(6000);
    repeat (20) @(negedge clk);

    // Corrupted echoes of bytes 1 and 3, plus a start pulse while busy that must be ignored
    mode = M_FLIP;
    issue_run(8'd5, 8'h40, 8'd2, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    num_bytes = 8'd9;
    seed      = 8'hAA;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000);
    repeat (20) @(negedge clk);

    // Bad stop bit on the echo of byte 0
    mode = M_BADSTOP;
    issue_run(8'd2, 8'h5A, 8'd1, 1'b0, 1'b0);
    wait_done(3000);
    repeat (30) @(negedge clk);

    // Empty run: done exactly three cycles after start, line untouched
    mode = M_LOOP;
    r.err = 8'd0;
    r.to  = 1'b0;
    r.ps  = 1'b1;
    exp_res.push_back(r);
    num_bytes = 8'd0;
    seed      = 8'h33;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check("zero_done_timing", done, (cyc == 3));
      check("zero_tx_idle", tx, 1'b1);
    end
    @(negedge clk);
    check("zero_done_one_cycle", done, 1'b0);
    repeat (10) @(negedge clk);

    // Reset in the middle of sending byte 2 aborts the run without a done pulse
    mode = M_LOOP;
    base = bytes_seen;
    run_byte  = 0;
    num_bytes = 8'd5;
    seed      = 8'h80;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (bytes_seen < base + 2 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("abort_two_bytes_sent", bytes_seen >= base + 2, 1'b1);
    c = 0;
    while (tx !== 1'b0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("abort_byte2_started", tx, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    base = done_seen;
    reset_n = 1'b0;
    #1;
    check("abort_tx_idle", tx, 1'b1);
    check("abort_busy_low", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_no_done", done_seen, base);

    // Next run after the abort behaves normally
    issue_run(8'd3, 8'h7E, 8'd0, 1'b0, 1'b1);
    wait_done(3000);
    repeat (20) @(negedge clk);
    check("all_results_seen", exp_res.size(), 0);
    check("all_bytes_seen", exp_line.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
